// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the fetch-stage sequencer:
//   - seqState_t  : fetch FSM states (IDLE/REQ/RESP/HOLD)
//   - redirSrc_t  : which redirect source won arbitration
//   - ADDR_W_DEF / INST_W_DEF : default address and instruction widths
// No ports (package).
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } seqState_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JMP  = 2'd1,
    SRC_BR   = 2'd2,
    SRC_TRAP = 2'd3
  } redirSrc_t;

endpackage

// File: rtl/pc_redirect_arb.sv
// ---------------------------------------------------------------------------
// pc_redirect_arb
// Purely combinational priority select between the PC redirect sources.
// Priority: trap > branch > jump (trap only when PC_SEQ_TRAP_EN is defined).
//
// Ports:
//   trap_valid_i/trap_vector_i : trap redirect (PC_SEQ_TRAP_EN only)
//   br_valid_i/br_target_i     : EX-stage branch redirect
//   jmp_valid_i/jmp_target_i   : ID-stage jump redirect
//   valid_o                    : some redirect is requested this cycle
//   target_o                   : target of the winning source (0 if none)
//   is_trap_o                  : winner is the trap (PC_SEQ_TRAP_EN only)
//
// Config macro: PC_SEQ_TRAP_EN
// ---------------------------------------------------------------------------
module pc_redirect_arb
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
`ifdef PC_SEQ_TRAP_EN
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_vector_i,
  output logic              is_trap_o,
`endif
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              jmp_valid_i,
  input  logic [ADDR_W-1:0] jmp_target_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] target_o
);

  redirSrc_t src;

  // Lowest priority first so each later assignment overrides it.
  always_comb begin
    src = SRC_NONE;
    if (jmp_valid_i) src = SRC_JMP;
    if (br_valid_i)  src = SRC_BR;
`ifdef PC_SEQ_TRAP_EN
    if (trap_valid_i) src = SRC_TRAP;
`endif
  end

  always_comb begin
    target_o = '0;
    case (src)
      SRC_BR:   target_o = br_target_i;
      SRC_JMP:  target_o = jmp_target_i;
`ifdef PC_SEQ_TRAP_EN
      SRC_TRAP: target_o = trap_vector_i;
`endif
      default:  target_o = '0;
    endcase
  end

  assign valid_o = (src != SRC_NONE);

`ifdef PC_SEQ_TRAP_EN
  assign is_trap_o = (src == SRC_TRAP);
`endif

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Fetch-stage controller. Drives the PC register's stall/branch/new-address
// inputs, runs the instruction-memory req/gnt/rvalid handshake, buffers the
// response for IF/ID while the backend stalls, and arbitrates redirects.
// A redirect that arrives while a fetch is outstanding is parked in a
// pending slot and applied in the cycle the (discarded) response returns.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   pc_value_i                : current PC register value
//   pc_stall_o                : hold the PC at the next edge
//   pc_branch_true_o          : load pc_new_addr_o at the next edge
//   pc_new_addr_o             : redirect target
//   imem_req_o/imem_addr_o    : fetch request and address (= pc_value_i)
//   imem_gnt_i                : request accepted (same-cycle)
//   imem_rvalid_i/imem_rdata_i: fetch response
//   inst_valid_o/inst_o       : instruction presented to IF/ID
//   pipe_stall_i              : backend cannot accept an instruction
//   br_valid_i/br_target_i    : EX-stage branch redirect
//   jmp_valid_i/jmp_target_i  : ID-stage jump redirect
//   trap_valid_i/trap_vector_i: trap redirect (PC_SEQ_TRAP_EN only)
//   flush_if_o                : one-cycle pulse killing the IF/ID entry
//
// Config macro: PC_SEQ_TRAP_EN adds the trap ports, makes trap the highest
// priority source and protects a pending trap from later br/jmp.
//
// inst_o/inst_valid_o form a registered stage: the instruction accepted in
// a response cycle is presented the following cycle, and stays presented for
// the whole of HOLD.
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_value_i,
  output logic              pc_stall_o,
  output logic              pc_branch_true_o,
  output logic [ADDR_W-1:0] pc_new_addr_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  input  logic              pipe_stall_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              jmp_valid_i,
  input  logic [ADDR_W-1:0] jmp_target_i,
`ifdef PC_SEQ_TRAP_EN
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_vector_i,
`endif
  output logic              flush_if_o
);

  seqState_t         state_q, state_d;
  logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
  logic              pendV_q, pendV_d;
  logic              discard_q, discard_d;
  logic [INST_W-1:0] instData_q, instData_d;
  logic              instValid_q, instValid_d;

  logic              redirValid;
  logic [ADDR_W-1:0] redirTarget;
  logic              redirTakes;
  logic [ADDR_W-1:0] slotAddr;

`ifdef PC_SEQ_TRAP_EN
  logic              pendTrap_q, pendTrap_d;
  logic              redirTrap;
`endif

  pc_redirect_arb #(
    .ADDR_W (ADDR_W)
  ) u_arb (
`ifdef PC_SEQ_TRAP_EN
    .trap_valid_i  (trap_valid_i),
    .trap_vector_i (trap_vector_i),
    .is_trap_o     (redirTrap),
`endif
    .br_valid_i    (br_valid_i),
    .br_target_i   (br_target_i),
    .jmp_valid_i   (jmp_valid_i),
    .jmp_target_i  (jmp_target_i),
    .valid_o       (redirValid),
    .target_o      (redirTarget)
  );

  // A new redirect may overwrite the pending slot unless the slot holds a
  // trap and the newcomer is not a trap.
`ifdef PC_SEQ_TRAP_EN
  assign redirTakes = redirValid && !(pendV_q && pendTrap_q && !redirTrap);
`else
  assign redirTakes = redirValid;
`endif

  // Target to apply when a discarded response returns: a same-cycle
  // redirect counts as the newest one.
  assign slotAddr = redirTakes ? redirTarget : pendAddr_q;

  assign imem_addr_o = pc_value_i;
  assign inst_o      = instData_q;

  always_comb begin
    state_d          = state_q;
    pendAddr_d       = pendAddr_q;
    pendV_d          = pendV_q;
    discard_d        = discard_q;
    instData_d       = instData_q;
    instValid_d      = 1'b0;
`ifdef PC_SEQ_TRAP_EN
    pendTrap_d       = pendTrap_q;
`endif
    pc_stall_o       = 1'b1;
    pc_branch_true_o = 1'b0;
    pc_new_addr_o    = redirTarget;
    imem_req_o       = 1'b0;
    flush_if_o       = 1'b0;
    inst_valid_o     = instValid_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirValid) begin
          pc_stall_o       = 1'b0;
          pc_branch_true_o = 1'b1;
          flush_if_o       = 1'b1;
        end
      end

      REQ: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) begin
          // The PC is committed to this fetch; park any redirect.
          state_d = RESP;
          if (redirValid) begin
            pendAddr_d = redirTarget;
            pendV_d    = 1'b1;
            discard_d  = 1'b1;
`ifdef PC_SEQ_TRAP_EN
            pendTrap_d = redirTrap;
`endif
          end
        end else if (redirValid) begin
          pc_stall_o       = 1'b0;
          pc_branch_true_o = 1'b1;
          flush_if_o       = 1'b1;
        end
      end

      RESP: begin
        if (redirTakes) begin
          pendAddr_d = redirTarget;
          pendV_d    = 1'b1;
          discard_d  = 1'b1;
`ifdef PC_SEQ_TRAP_EN
          pendTrap_d = redirTrap;
`endif
        end
        if (imem_rvalid_i) begin
          state_d = REQ;
          if (discard_q || redirValid) begin
            // Response belongs to the wrong path: drop it and redirect.
            pc_stall_o       = 1'b0;
            pc_branch_true_o = 1'b1;
            pc_new_addr_o    = slotAddr;
            flush_if_o       = 1'b1;
            pendV_d          = 1'b0;
            discard_d        = 1'b0;
`ifdef PC_SEQ_TRAP_EN
            pendTrap_d       = 1'b0;
`endif
          end else if (pipe_stall_i) begin
            state_d     = HOLD;
            instData_d  = imem_rdata_i;
            instValid_d = 1'b1;
          end else begin
            pc_stall_o  = 1'b0;
            instData_d  = imem_rdata_i;
            instValid_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (redirValid) begin
          // Redirect beats the stall; the buffered instruction is dropped.
          state_d          = REQ;
          pc_stall_o       = 1'b0;
          pc_branch_true_o = 1'b1;
          flush_if_o       = 1'b1;
          inst_valid_o     = 1'b0;
        end else if (!pipe_stall_i) begin
          state_d    = REQ;
          pc_stall_o = 1'b0;
        end else begin
          instValid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pendAddr_q  <= '0;
      pendV_q     <= 1'b0;
      discard_q   <= 1'b0;
      instData_q  <= '0;
      instValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pendAddr_q  <= pendAddr_d;
      pendV_q     <= pendV_d;
      discard_q   <= discard_d;
      instData_q  <= instData_d;
      instValid_q <= instValid_d;
    end
  end

`ifdef PC_SEQ_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pendTrap_q <= 1'b0;
    end else begin
      pendTrap_q <= pendTrap_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. The bench owns the PC register and
// the instruction memory; memory returns 0xA0 + address as the instruction.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int AW = 32;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pcReg;
  logic          pc_stall_o, pc_branch_true_o;
  logic [AW-1:0] pc_new_addr_o;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_gnt_i, imem_rvalid_i;
  logic [IW-1:0] imem_rdata_i;
  logic          inst_valid_o;
  logic [IW-1:0] inst_o;
  logic          pipe_stall_i;
  logic          br_valid_i, jmp_valid_i;
  logic [AW-1:0] br_target_i, jmp_target_i;
  logic          flush_if_o;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_value_i       (pcReg),
    .pc_stall_o       (pc_stall_o),
    .pc_branch_true_o (pc_branch_true_o),
    .pc_new_addr_o    (pc_new_addr_o),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .pipe_stall_i     (pipe_stall_i),
    .br_valid_i       (br_valid_i),
    .br_target_i      (br_target_i),
    .jmp_valid_i      (jmp_valid_i),
    .jmp_target_i     (jmp_target_i),
`ifdef PC_SEQ_TRAP_EN
    .trap_valid_i     (1'b0),
    .trap_vector_i    ('0),
`endif
    .flush_if_o       (flush_if_o)
  );

  always #5 clk = ~clk;

  // The PC register the sequencer controls.
  always @(posedge clk) begin
    if (rst) pcReg <= '0;
    else if (!pc_stall_o) pcReg <= pc_branch_true_o ? pc_new_addr_o : pcReg + 1;
  end

  function automatic logic [IW-1:0] instAt(input logic [AW-1:0] a);
    return 32'hA0 + a;
  endfunction

  task automatic stepClk();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    pipe_stall_i  = 1'b0;
    br_valid_i    = 1'b0;
    jmp_valid_i   = 1'b0;
    br_target_i   = '0;
    jmp_target_i  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearInputs();
    stepClk();
    stepClk();
    rst = 1'b0;
    #1;
    checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_pc_stall got=%0b exp=1", pc_stall_o); end
    checks++; if (pc_branch_true_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_branch got=%0b exp=0", pc_branch_true_o); end
    checks++; if (pc_new_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_new_addr got=%h exp=0", pc_new_addr_o); end
    checks++; if (imem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%0b exp=0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b exp=0", inst_valid_o); end
    checks++; if (inst_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst got=%h exp=0", inst_o); end
    checks++; if (flush_if_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush got=%0b exp=0", flush_if_o); end
    stepClk();
    #1;
    checks++; if (imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL idle_to_req got=%0b exp=1", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL first_addr got=%h exp=0", imem_addr_o); end
  endtask

  task automatic test_basic_fetch();
    for (int k = 0; k < 4; k++) begin
      stepClk(); clearInputs(); imem_gnt_i = 1'b1; #1;
      checks++; if (imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL basic_req[%0d] got=%0b exp=1", k, imem_req_o); end
      checks++; if (imem_addr_o !== AW'(k)) begin failures++; $display("[TB] FAIL basic_addr[%0d] got=%h exp=%h", k, imem_addr_o, AW'(k)); end
      checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("[TB] FAIL basic_stall_req[%0d] got=%0b exp=1", k, pc_stall_o); end
      if (k > 0) begin
        checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid[%0d] got=%0b exp=1", k, inst_valid_o); end
        checks++; if (inst_o !== instAt(AW'(k - 1))) begin failures++; $display("[TB] FAIL basic_inst[%0d] got=%h exp=%h", k, inst_o, instAt(AW'(k - 1))); end
      end
      stepClk(); clearInputs(); imem_rvalid_i = 1'b1; imem_rdata_i = instAt(AW'(k)); #1;
      checks++; if (pc_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_advance[%0d] got=%0b exp=0", k, pc_stall_o); end
      checks++; if (pc_branch_true_o !== 1'b0) begin failures++; $display("[TB] FAIL basic_branch[%0d] got=%0b exp=0", k, pc_branch_true_o); end
    end
    stepClk(); clearInputs(); #1;
    checks++; if (inst_o !== 32'hA3 || inst_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL basic_last_inst got=%h/%0b exp=a3/1", inst_o, inst_valid_o); end
    checks++; if (imem_addr_o !== 32'h4) begin failures++; $display("[TB] FAIL basic_next_addr got=%h exp=4", imem_addr_o); end
  endtask

  task automatic test_hold();
    stepClk(); clearInputs(); imem_gnt_i = 1'b1; #1;
    stepClk(); clearInputs(); imem_rvalid_i = 1'b1; imem_rdata_i = instAt(32'h4); pipe_stall_i = 1'b1; #1;
    checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("[TB] FAIL hold_entry_stall got=%0b exp=1", pc_stall_o); end
    for (int i = 0; i < 2; i++) begin
      stepClk(); clearInputs(); pipe_stall_i = 1'b1; #1;
      checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL hold_valid[%0d] got=%0b exp=1", i, inst_valid_o); end
      checks++; if (inst_o !== 32'hA4) begin failures++; $display("[TB] FAIL hold_inst[%0d] got=%h exp=a4", i, inst_o); end
      checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("[TB] FAIL hold_stall[%0d] got=%0b exp=1", i, pc_stall_o); end
      checks++; if (imem_addr_o !== 32'h4) begin failures++; $display("[TB] FAIL hold_pc[%0d] got=%h exp=4", i, imem_addr_o); end
    end
    stepClk(); clearInputs(); #1;
    checks++; if (pc_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL hold_release got=%0b exp=0", pc_stall_o); end
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'hA4) begin failures++; $display("[TB] FAIL hold_release_inst got=%h/%0b exp=a4/1", inst_o, inst_valid_o); end
    stepClk(); clearInputs(); #1;
    checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL hold_after_valid got=%0b exp=0", inst_valid_o); end
    checks++; if (imem_addr_o !== 32'h5 || imem_req_o !== 1'b1) begin failures++; $display("[TB] FAIL hold_after_addr got=%h/%0b exp=5/1", imem_addr_o, imem_req_o); end
  endtask

  task automatic test_br_resp();
    stepClk(); clearInputs(); imem_gnt_i = 1'b1; #1;
    stepClk(); clearInputs(); br_valid_i = 1'b1; br_target_i = 32'h40; #1;
    checks++; if (pc_stall_o !== 1'b1 || flush_if_o !== 1'b0) begin failures++; $display("[TB] FAIL br_resp_parked got=%0b/%0b exp=1/0", pc_stall_o, flush_if_o); end
    stepClk(); clearInputs(); #1;
    checks++; if (pc_branch_true_o !== 1'b0) begin failures++; $display("[TB] FAIL br_resp_wait got=%0b exp=0", pc_branch_true_o); end
    stepClk(); clearInputs(); imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD; #1;
    checks++; if (pc_branch_true_o !== 1'b1 || pc_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL br_resp_apply got=%0b/%0b exp=1/0", pc_branch_true_o, pc_stall_o); end
    checks++; if (pc_new_addr_o !== 32'h40) begin failures++; $display("[TB] FAIL br_resp_target got=%h exp=40", pc_new_addr_o); end
    checks++; if (flush_if_o !== 1'b1) begin failures++; $display("[TB] FAIL br_resp_flush got=%0b exp=1", flush_if_o); end
    stepClk(); clearInputs(); #1;
    checks++; if (imem_addr_o !== 32'h40) begin failures++; $display("[TB] FAIL br_resp_refetch got=%h exp=40", imem_addr_o); end
    checks++; if (inst_valid_o !== 1'b0 || flush_if_o !== 1'b0) begin failures++; $display("[TB] FAIL br_resp_dropped got=%0b/%0b exp=0/0", inst_valid_o, flush_if_o); end
  endtask

  task automatic test_redirect_in_req();
    logic [AW-1:0] brT, jmpT;
    brT  = $urandom;
    jmpT = $urandom;
    stepClk(); clearInputs(); br_valid_i = 1'b1; br_target_i = brT; jmp_valid_i = 1'b1; jmp_target_i = jmpT; #1;
    checks++; if (pc_new_addr_o !== brT) begin failures++; $display("[TB] FAIL req_prio_target got=%h exp=%h", pc_new_addr_o, brT); end
    checks++; if (pc_branch_true_o !== 1'b1 || pc_stall_o !== 1'b0 || flush_if_o !== 1'b1) begin failures++; $display("[TB] FAIL req_prio_apply got=%0b/%0b/%0b exp=1/0/1", pc_branch_true_o, pc_stall_o, flush_if_o); end
    stepClk(); clearInputs(); jmp_valid_i = 1'b1; jmp_target_i = jmpT; #1;
    checks++; if (imem_addr_o !== brT) begin failures++; $display("[TB] FAIL req_br_addr got=%h exp=%h", imem_addr_o, brT); end
    checks++; if (pc_new_addr_o !== jmpT || pc_branch_true_o !== 1'b1) begin failures++; $display("[TB] FAIL req_jmp_apply got=%h/%0b exp=%h/1", pc_new_addr_o, pc_branch_true_o, jmpT); end
    stepClk(); clearInputs(); #1;
    checks++; if (imem_addr_o !== jmpT || pc_branch_true_o !== 1'b0) begin failures++; $display("[TB] FAIL req_jmp_addr got=%h/%0b exp=%h/0", imem_addr_o, pc_branch_true_o, jmpT); end
  endtask

  task automatic test_jmp_then_br();
    logic [AW-1:0] r;
    stepClk(); clearInputs(); imem_gnt_i = 1'b1; #1;
    stepClk(); clearInputs(); jmp_valid_i = 1'b1; jmp_target_i = 32'h80; #1;
    checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("[TB] FAIL jb_jmp_parked got=%0b exp=1", pc_stall_o); end
    stepClk(); clearInputs(); br_valid_i = 1'b1; br_target_i = 32'h90; #1;
    checks++; if (pc_branch_true_o !== 1'b0) begin failures++; $display("[TB] FAIL jb_br_parked got=%0b exp=0", pc_branch_true_o); end
    stepClk(); clearInputs(); imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBEEF; #1;
    checks++; if (pc_new_addr_o !== 32'h90 || pc_branch_true_o !== 1'b1) begin failures++; $display("[TB] FAIL jb_apply got=%h/%0b exp=90/1", pc_new_addr_o, pc_branch_true_o); end
    stepClk(); clearInputs(); #1;
    checks++; if (imem_addr_o !== 32'h90) begin failures++; $display("[TB] FAIL jb_refetch got=%h exp=90", imem_addr_o); end
    // Redirect in the same cycle as the grant is parked, not applied.
    r = $urandom;
    stepClk(); clearInputs(); imem_gnt_i = 1'b1; jmp_valid_i = 1'b1; jmp_target_i = r; #1;
    checks++; if (pc_stall_o !== 1'b1 || pc_branch_true_o !== 1'b0) begin failures++; $display("[TB] FAIL gnt_redir_parked got=%0b/%0b exp=1/0", pc_stall_o, pc_branch_true_o); end
    stepClk(); clearInputs(); imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234; #1;
    checks++; if (pc_branch_true_o !== 1'b1 || pc_new_addr_o !== r) begin failures++; $display("[TB] FAIL gnt_redir_apply got=%0b/%h exp=1/%h", pc_branch_true_o, pc_new_addr_o, r); end
    stepClk(); clearInputs(); #1;
    checks++; if (imem_addr_o !== r || inst_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL gnt_redir_refetch got=%h/%0b exp=%h/0", imem_addr_o, inst_valid_o, r); end
  endtask

  task automatic test_redirect_hold();
    logic [AW-1:0] brT;
    brT = $urandom;
    stepClk(); clearInputs(); imem_gnt_i = 1'b1; #1;
    stepClk(); clearInputs(); imem_rvalid_i = 1'b1; imem_rdata_i = 32'h5A5A; pipe_stall_i = 1'b1; #1;
    stepClk(); clearInputs(); pipe_stall_i = 1'b1; #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h5A5A) begin failures++; $display("[TB] FAIL rh_hold got=%h/%0b exp=5a5a/1", inst_o, inst_valid_o); end
    stepClk(); clearInputs(); pipe_stall_i = 1'b1; br_valid_i = 1'b1; br_target_i = brT; #1;
    checks++; if (pc_branch_true_o !== 1'b1 || pc_stall_o !== 1'b0 || pc_new_addr_o !== brT) begin failures++; $display("[TB] FAIL rh_apply got=%0b/%0b/%h exp=1/0/%h", pc_branch_true_o, pc_stall_o, pc_new_addr_o, brT); end
    checks++; if (inst_valid_o !== 1'b0 || flush_if_o !== 1'b1) begin failures++; $display("[TB] FAIL rh_drop got=%0b/%0b exp=0/1", inst_valid_o, flush_if_o); end
    stepClk(); clearInputs(); #1;
    checks++; if (imem_addr_o !== brT || inst_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rh_refetch got=%h/%0b exp=%h/0", imem_addr_o, inst_valid_o, brT); end
  endtask

  task automatic test_reset_mid();
    stepClk(); clearInputs(); imem_gnt_i = 1'b1; #1;
    stepClk(); clearInputs(); br_valid_i = 1'b1; br_target_i = 32'h55; #1;
    stepClk(); clearInputs(); rst = 1'b1; #1;
    stepClk(); clearInputs(); rst = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD; #1;
    checks++; if (pc_stall_o !== 1'b1 || pc_branch_true_o !== 1'b0 || pc_new_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL rm_pc_outputs got=%0b/%0b/%h exp=1/0/0", pc_stall_o, pc_branch_true_o, pc_new_addr_o); end
    checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || flush_if_o !== 1'b0) begin failures++; $display("[TB] FAIL rm_ctrl got=%0b/%0b/%0b exp=0/0/0", imem_req_o, inst_valid_o, flush_if_o); end
    checks++; if (inst_o !== 32'h0) begin failures++; $display("[TB] FAIL rm_inst got=%h exp=0", inst_o); end
    stepClk(); clearInputs(); #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || pc_branch_true_o !== 1'b0) begin failures++; $display("[TB] FAIL rm_refetch got=%0b/%h/%0b exp=1/0/0", imem_req_o, imem_addr_o, pc_branch_true_o); end
    stepClk(); clearInputs(); imem_gnt_i = 1'b1; #1;
    stepClk(); clearInputs(); imem_rvalid_i = 1'b1; imem_rdata_i = instAt(32'h0); #1;
    checks++; if (pc_stall_o !== 1'b0 || pc_branch_true_o !== 1'b0) begin failures++; $display("[TB] FAIL rm_pend_cleared got=%0b/%0b exp=0/0", pc_stall_o, pc_branch_true_o); end
    stepClk(); clearInputs(); #1;
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'hA0) begin failures++; $display("[TB] FAIL rm_first_inst got=%h/%0b exp=a0/1", inst_o, inst_valid_o); end
  endtask

  // Random grant/response latency and backend stalls, no redirects: the
  // instruction stream seen by IF/ID must be program order from address 0,
  // and the k-th granted fetch must be at address k.
  task automatic test_random_stream();
    int            grants = 0;
    int            delivered = 0;
    bit            prevValid = 1'b0;
    bit            outstanding = 1'b0;
    int            lat = 0;
    logic [AW-1:0] outAddr = '0;
    rst = 1'b1;
    clearInputs();
    stepClk();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      stepClk(); clearInputs();
      if (outstanding && lat == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = instAt(outAddr);
        outstanding   = 1'b0;
      end else if (outstanding) begin
        lat--;
      end else if (imem_req_o && $urandom_range(0, 3) != 0) begin
        imem_gnt_i = 1'b1;
        checks++; if (imem_addr_o !== AW'(grants)) begin failures++; $display("[TB] FAIL rnd_fetch_addr[%0d] got=%h exp=%h", grants, imem_addr_o, AW'(grants)); end
        outAddr     = imem_addr_o;
        grants++;
        outstanding = 1'b1;
        lat         = $urandom_range(0, 2);
      end
      pipe_stall_i = ($urandom_range(0, 2) == 0);
      #1;
      if (inst_valid_o) begin
        if (!prevValid) begin
          checks++; if (inst_o !== instAt(AW'(delivered))) begin failures++; $display("[TB] FAIL rnd_inst[%0d] got=%h exp=%h", delivered, inst_o, instAt(AW'(delivered))); end
          delivered++;
        end else begin
          checks++; if (inst_o !== instAt(AW'(delivered - 1))) begin failures++; $display("[TB] FAIL rnd_hold_inst[%0d] got=%h exp=%h", delivered - 1, inst_o, instAt(AW'(delivered - 1))); end
        end
      end
      prevValid = inst_valid_o;
    end
    checks++; if (delivered < 20) begin failures++; $display("[TB] FAIL rnd_progress got=%0d exp>=20", delivered); end
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    test_reset();
    test_basic_fetch();
    test_hold();
    test_br_resp();
    test_redirect_in_req();
    test_jmp_then_br();
    test_redirect_hold();
    test_reset_mid();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that drives the program-counter register's `stall`, `branch_true` and `new_addr` inputs. It runs the instruction-memory request/grant/response handshake and hands fetched instructions to IF/ID. It arbitrates redirect sources and holds the PC while the backend stalls. It sits between the PC register, instruction memory and the IF/ID pipeline register.

## Interface
- `ADDR_W`, 32: instruction address width; word-indexed, PC increments by 1.
- `INST_W`, 32: instruction width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `pc_value` in ADDR_W: current PC register output.
- `pc_stall` out 1: hold PC this edge.
- `pc_branch_true` out 1: load `pc_new_addr` this edge.
- `pc_new_addr` out ADDR_W: redirect target.
- `imem_req` out 1: fetch request.
- `imem_addr` out ADDR_W: fetch address; equals `pc_value`.
- `imem_gnt` in 1: request accepted (same-cycle sample).
- `imem_rvalid` in 1: response valid.
- `imem_rdata` in INST_W: response data.
- `inst_valid` out 1: instruction presented to IF/ID.
- `inst_o` out INST_W: instruction to IF/ID.
- `pipe_stall` in 1: backend cannot accept an instruction.
- `br_valid` in 1, `br_target` in ADDR_W: EX-stage branch redirect.
- `jmp_valid` in 1, `jmp_target` in ADDR_W: ID-stage jump redirect.
- `flush_if` out 1: pulse that kills the instruction currently in IF/ID.

## Operation
- FSM states:
  - `IDLE`: one cycle after reset, then `REQ`.
  - `REQ`: `imem_req`=1 until `imem_gnt`.
  - `RESP`: granted, waiting for `imem_rvalid`.
  - `HOLD`: response buffered, `pipe_stall` high.
- Transitions:
  - `REQ` with `gnt` goes to `RESP`.
  - `RESP` with `rvalid`: if `!pipe_stall` and no discard, deliver and advance the PC, then go to `REQ`; if `pipe_stall`, go to `HOLD`.
  - `HOLD` with `!pipe_stall`: deliver, advance, go to `REQ`.
- Advance: `pc_stall`=0, `pc_branch_true`=0. In every other cycle `pc_stall`=1 unless a redirect is applied.
- Redirect priority: br over jmp. Selected target goes to `pc_new_addr`. Applying it drives `pc_stall`=0, `pc_branch_true`=1 and `flush_if`=1 for one cycle.
- Apply immediately in `IDLE`, in `REQ` without same-cycle `gnt`, and in `HOLD` (buffer dropped, `inst_valid`=0). Next state is `REQ`.
- In `RESP`, or `REQ` with same-cycle `gnt`:
  - Latch the target into `pend_addr`; set `pend_v` and `discard`.
  - A newer redirect before the response overwrites `pend_addr`.
  - On `rvalid`: data dropped, pending redirect applied that cycle, `pend_v`/`discard` cleared, go to `REQ`.
- Redirect together with `pipe_stall`: redirect wins.
- `inst_o` is registered from `imem_rdata` on `rvalid`. `inst_valid` is high in the deliver cycle and throughout `HOLD`.
- Reset mid-transaction: return to `IDLE`, clear `pend_v`/`discard`. Any `rvalid` in `IDLE` is ignored; memory is reset with the core.

## Timing
- Reset values:
  - `pc_stall`=1, `pc_branch_true`=0, `pc_new_addr`=0.
  - `imem_req`=0, `inst_valid`=0, `inst_o`=0, `flush_if`=0.
  - State `IDLE`.
- `pc_stall`, `pc_branch_true`, `pc_new_addr`, `flush_if` and `imem_req` are combinational from state plus inputs. The PC register updates on the following edge.
- Minimum fetch: `REQ`+`gnt` at cycle n, `rvalid` at n+1, then the PC advances at the edge ending n+1, giving one instruction per 2 cycles.
- Redirect latency: 0 cycles when no fetch is outstanding. Otherwise it is applied in the `rvalid` cycle.

## Configuration
- `PC_SEQ_TRAP_EN` defined:
  - Adds ports `trap_valid` in 1 and `trap_vector` in ADDR_W.
  - Priority is trap > br > jmp.
  - A trap is also latched into the pending slot, and a later br/jmp cannot overwrite a pending trap.
- `PC_SEQ_TRAP_EN` undefined: ports absent, priority is br > jmp.

## Structure
- Shared package:
  - FSM state enum (`IDLE`/`REQ`/`RESP`/`HOLD`).
  - Redirect-source enum.
  - `ADDR_W`/`INST_W` defaults.
- Sub-module `pc_redirect_arb`: combinational priority select of valid plus target.
- The FSM and pending register live in `pc_sequencer`.

## Test plan
- Reset, then `gnt` and `rvalid` return on consecutive cycles with data 0xA0..0xA3 → addresses 0,1,2,3; `inst_o` sequence 0xA0..0xA3; `pc_stall` low every 2nd cycle.
- `pipe_stall` high for 3 cycles at `rvalid` → `HOLD`; `inst_valid` held with the same `inst_o`; PC unchanged; advance on release.
- `br_valid` with target 0x40 in `RESP` → response dropped; `pc_branch_true`=1 in the `rvalid` cycle; next `imem_addr`=0x40; `flush_if` pulses.
- `br` (0x40) and `jmp` (0x80) in the same `REQ` cycle without `gnt` → `pc_new_addr`=0x40 immediately.
- `jmp` 0x80 then `br` 0x90 during one `RESP` → after `rvalid`, fetch 0x90.
- `rst` asserted in `RESP` → outputs at reset values next cycle; a late `rvalid` is ignored; refetch from 0.
